// File: rtl/processor_pkg.sv
// processor_pkg
//   Shared definitions for the multi-cycle processor datapath:
//   - opcode constants for the current ISA revision (NOP, STORE, ADD, SUB)
//   - the sequencer FSM state encoding
//   - default datapath widths used as parameter defaults by the blocks
//   - small opcode-classification helpers
package processor_pkg;

  localparam int DEFAULT_WORDSIZE   = 64;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_MEM_ADDR_W = 5;
  localparam int DEFAULT_CNT_W      = 16;

  localparam int OP_W = 7;

  localparam logic [OP_W-1:0] OP_NOP   = 7'h00;
  localparam logic [OP_W-1:0] OP_STORE = 7'h01;
  localparam logic [OP_W-1:0] OP_ADD   = 7'h02;
  localparam logic [OP_W-1:0] OP_SUB   = 7'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

  // Opcode is part of the ISA (anything else raises illegal_op).
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcode needs the register file and adder, i.e. walks READ/EXEC.
  function automatic logic uses_datapath(input logic [OP_W-1:0] op);
    return (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Opcode writes a result back to the register file.
  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Multi-cycle controller for the processor datapath (register file, data
//   memory, adder/subtractor). Accepts one instruction per valid/ready
//   handshake and walks it through READ -> EXEC -> WB; NOP and illegal
//   opcodes skip straight to WB.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   instr_valid/instr_ready instruction handshake (ready only in IDLE)
//   instr_op/rs1/rs2/rd     instruction fields, held by source until accepted
//   rf_addr_a/b, rf_data_a/b register-file read ports
//   rf_write_en/addr/data   register-file write port
//   alu_a/alu_b/alu_sub     adder/subtractor operands and mode
//   alu_result              adder/subtractor result (combinational)
//   dm_addr/dm_data_input/dm_write_enable/dm_read  data-memory port
//   done                    1-cycle retire pulse
//   illegal_op              1-cycle pulse with done for unknown opcodes
//   retired_count           wrapping retired-instruction counter
module datapath_sequencer
  import processor_pkg::*;
#(
  parameter int WORDSIZE   = DEFAULT_WORDSIZE,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MEM_ADDR_W = DEFAULT_MEM_ADDR_W,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OP_W-1:0]       instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rs1,
  input  logic [REG_ADDR_W-1:0] instr_rs2,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  output logic [REG_ADDR_W-1:0] rf_addr_a,
  output logic [REG_ADDR_W-1:0] rf_addr_b,
  input  logic [WORDSIZE-1:0]   rf_data_a,
  input  logic [WORDSIZE-1:0]   rf_data_b,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [WORDSIZE-1:0]   rf_write_data,
  output logic [WORDSIZE-1:0]   alu_a,
  output logic [WORDSIZE-1:0]   alu_b,
  output logic                  alu_sub,
  input  logic [WORDSIZE-1:0]   alu_result,
  output logic [MEM_ADDR_W-1:0] dm_addr,
  output logic [WORDSIZE-1:0]   dm_data_input,
  output logic                  dm_write_enable,
  output logic                  dm_read,
  output logic                  done,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      retired_count
);

  seq_state_e state_q, state_d;

  logic [OP_W-1:0]       op_q,  op_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,  rd_d;
  logic [WORDSIZE-1:0]   opa_q, opa_d;
  // Operand B only ever leaves the block as a store address, so only the
  // address slice is kept.
  logic [MEM_ADDR_W-1:0] opb_addr_q, opb_addr_d;
  logic [WORDSIZE-1:0]   res_q, res_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_addr_q <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      opa_q      <= opa_d;
      opb_addr_q <= opb_addr_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    opa_d      = opa_q;
    opb_addr_d = opb_addr_q;
    res_d      = res_q;
    cnt_d      = cnt_q;

    instr_ready     = 1'b0;
    rf_addr_a       = '0;
    rf_addr_b       = '0;
    rf_write_en     = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    alu_a           = '0;
    alu_b           = '0;
    alu_sub         = 1'b0;
    dm_addr         = '0;
    dm_data_input   = '0;
    dm_write_enable = 1'b0;
    done            = 1'b0;
    illegal_op      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          rd_d    = instr_rd;
          state_d = uses_datapath(instr_op) ? ST_READ : ST_WB;
        end
      end

      ST_READ, ST_EXEC: begin
        // Addresses are held through EXEC so a register file with either a
        // combinational or a one-cycle registered read delivers valid data
        // by the end of EXEC. STORE reads its address register on port B.
        rf_addr_a = rs1_q;
        rf_addr_b = (op_q == OP_STORE) ? rd_q : rs2_q;
        if (state_q == ST_EXEC) begin
          alu_a      = rf_data_a;
          alu_b      = rf_data_b;
          alu_sub    = (op_q == OP_SUB);
          opa_d      = rf_data_a;
          opb_addr_d = rf_data_b[MEM_ADDR_W-1:0];
          res_d      = alu_result;
          state_d    = ST_WB;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_WB: begin
        done       = 1'b1;
        illegal_op = !is_legal_op(op_q);
        cnt_d      = cnt_q + CNT_W'(1);
        if (is_arith_op(op_q)) begin
          // r0 is hard-wired to zero, so a write to it is dropped here.
          rf_write_en   = (rd_q != '0);
          rf_write_addr = rd_q;
          rf_write_data = res_q;
        end
        if (op_q == OP_STORE) begin
          dm_write_enable = 1'b1;
          dm_addr         = opb_addr_q;
          dm_data_input   = opa_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // No loads in this ISA revision.
  assign dm_read       = 1'b0;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer
//   Self-checking bench for datapath_sequencer. The bench plays the
//   register file, data memory and adder/subtractor, and keeps an
//   architectural reference (register array, memory array, retire count)
//   that is updated from the ISA rules per instruction.
module tb_datapath_sequencer;
  import processor_pkg::*;

  localparam int W  = 64;
  localparam int RA = 5;
  localparam int MA = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [6:0]    instr_op;
  logic [RA-1:0] instr_rs1, instr_rs2, instr_rd;
  logic [RA-1:0] rf_addr_a, rf_addr_b;
  logic [W-1:0]  rf_data_a, rf_data_b;
  logic          rf_write_en;
  logic [RA-1:0] rf_write_addr;
  logic [W-1:0]  rf_write_data;
  logic [W-1:0]  alu_a, alu_b;
  logic          alu_sub;
  logic [W-1:0]  alu_result;
  logic [MA-1:0] dm_addr;
  logic [W-1:0]  dm_data_input;
  logic          dm_write_enable;
  logic          dm_read;
  logic          done;
  logic          illegal_op;
  logic [CW-1:0] retired_count;

  always #5 clk = ~clk;

  datapath_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_op        (instr_op),
    .instr_rs1       (instr_rs1),
    .instr_rs2       (instr_rs2),
    .instr_rd        (instr_rd),
    .rf_addr_a       (rf_addr_a),
    .rf_addr_b       (rf_addr_b),
    .rf_data_a       (rf_data_a),
    .rf_data_b       (rf_data_b),
    .rf_write_en     (rf_write_en),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_sub         (alu_sub),
    .alu_result      (alu_result),
    .dm_addr         (dm_addr),
    .dm_data_input   (dm_data_input),
    .dm_write_enable (dm_write_enable),
    .dm_read         (dm_read),
    .done            (done),
    .illegal_op      (illegal_op),
    .retired_count   (retired_count)
  );

  // Environment: register file (combinational read, r0 = 0), memory, adder.
  logic [W-1:0]  rf_arr  [32];
  logic [W-1:0]  mem_arr [32];
  logic          clr, pre_en;
  logic [RA-1:0] pre_addr;
  logic [W-1:0]  pre_data;

  assign rf_data_a  = (rf_addr_a == '0) ? '0 : rf_arr[rf_addr_a];
  assign rf_data_b  = (rf_addr_b == '0) ? '0 : rf_arr[rf_addr_b];
  assign alu_result = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) begin
        rf_arr[i]  <= '0;
        mem_arr[i] <= '0;
      end
    end else begin
      if (pre_en)
        rf_arr[pre_addr] <= pre_data;
      else if (rf_write_en && rf_write_addr != '0)
        rf_arr[rf_write_addr] <= rf_write_data;
      if (dm_write_enable)
        mem_arr[dm_addr] <= dm_data_input;
    end
  end

  // Architectural reference.
  logic [W-1:0] ref_rf  [32];
  logic [W-1:0] ref_mem [32];
  int           ref_count;

  int compared   = 0;
  int mismatched = 0;

  // Outputs seen on the most recent done cycle, for directed checks.
  logic [W-1:0]  last_rf_data, last_dm_data;
  logic [MA-1:0] last_dm_addr;
  logic          last_rf_en, last_dm_en;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [RA-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
    if (a != '0) ref_rf[a] = d;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [RA-1:0] rs1,
                           input logic [RA-1:0] rs2, input logic [RA-1:0] rd);
    logic [W-1:0]  a, b, dv, exp_res;
    logic          arith, store, legal, exp_rf_en;
    logic [MA-1:0] exp_dm_addr;
    int            exp_lat, got;
    a         = (rs1 == '0) ? '0 : ref_rf[rs1];
    b         = (rs2 == '0) ? '0 : ref_rf[rs2];
    dv        = (rd  == '0) ? '0 : ref_rf[rd];
    arith     = (op == 7'h02) || (op == 7'h03);
    store     = (op == 7'h01);
    legal     = (op <= 7'h03);
    exp_lat   = (arith || store) ? 3 : 1;
    exp_res   = (op == 7'h02) ? a + b : a - b;
    exp_rf_en = arith && (rd != '0);
    exp_dm_addr = dv[MA-1:0];

    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_rd    = rd;
    check("ready_before_accept", instr_ready, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;

    got = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = n;
        break;
      end
      check("no_strobe_before_done", {rf_write_en, dm_write_enable, illegal_op}, 0);
    end
    check("done_latency", got, exp_lat);
    if (got == 0) return;

    last_rf_en   = rf_write_en;
    last_rf_data = rf_write_data;
    last_dm_en   = dm_write_enable;
    last_dm_addr = dm_addr;
    last_dm_data = dm_data_input;

    check("illegal_op", illegal_op, !legal);
    check("rf_write_en", rf_write_en, exp_rf_en);
    if (exp_rf_en) begin
      check("rf_write_addr", rf_write_addr, rd);
      check("rf_write_data", rf_write_data, exp_res);
    end
    check("dm_write_enable", dm_write_enable, store);
    if (store) begin
      check("dm_addr", dm_addr, exp_dm_addr);
      check("dm_data_input", dm_data_input, a);
    end
    check("dm_read", dm_read, 0);
    check("retired_count", retired_count, ref_count);

    if (exp_rf_en) ref_rf[rd] = exp_res;
    if (store) ref_mem[exp_dm_addr] = a;
    ref_count = (ref_count + 1) % (1 << CW);
    $display("instr op=%02h rs1=%0d rs2=%0d rd=%0d latency=%0d count=%0d",
             op, rs1, rs2, rd, got, ref_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]    rop;
    logic [RA-1:0] r1, r2, rdd;
    int            sel;

    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_rd    = '0;
    pre_en      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    clr         = 1'b1;
    rst_n       = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ref_rf[i]  = '0;
      ref_mem[i] = '0;
    end
    ref_count = 0;

    // 1. Reset state
    repeat (3) @(negedge clk);
    check("reset_done", done, 0);
    check("reset_strobes", {rf_write_en, dm_write_enable, illegal_op}, 0);
    check("reset_count", retired_count, 0);
    check("reset_rf_write_data", rf_write_data, 0);
    check("reset_dm_addr", dm_addr, 0);
    rst_n = 1'b1;
    clr   = 1'b0;
    @(negedge clk);
    check("ready_after_reset", instr_ready, 1);
    check("count_after_reset", retired_count, 0);

    // 2. ADD
    preload(5'd2, 64'd5);
    preload(5'd3, 64'd7);
    run_instr(OP_ADD, 5'd2, 5'd3, 5'd10);
    check("add_data_12", last_rf_data, 64'd12);

    // 3. SUB wrapping negative
    preload(5'd4, 64'd3);
    preload(5'd5, 64'd5);
    run_instr(OP_SUB, 5'd4, 5'd5, 5'd14);
    check("sub_data_minus2", last_rf_data, 64'hFFFF_FFFF_FFFF_FFFE);

    // 4. STORE
    preload(5'd4, 64'hAB);
    preload(5'd7, 64'd9);
    run_instr(OP_STORE, 5'd4, 5'd0, 5'd7);
    check("store_addr_9", last_dm_addr, 9);
    check("store_data_ab", last_dm_data, 64'hAB);
    check("store_no_rf_write", last_rf_en, 0);

    // 5. Illegal opcode, NOP, ADD to r0
    run_instr(7'h7F, 5'd1, 5'd2, 5'd3);
    run_instr(OP_NOP, 5'd0, 5'd0, 5'd0);
    run_instr(OP_ADD, 5'd2, 5'd3, 5'd0);
    check("add_r0_no_write", last_rf_en, 0);

    // 6a. Reset during EXEC of an ADD: nothing retires, counter clears.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = OP_ADD;
    instr_rs1   = 5'd2;
    instr_rs2   = 5'd3;
    instr_rd    = 5'd11;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);            // READ
    @(negedge clk);            // EXEC
    rst_n = 1'b0;
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_count_cleared", retired_count, 0);
    ref_count = 0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_write_in_reset", {rf_write_en, dm_write_enable, done}, 0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_write_after", {rf_write_en, dm_write_enable, done}, 0);
      check("abort_count", retired_count, ref_count);
    end
    check("abort_r11_untouched", rf_arr[11], ref_rf[11]);

    // 6b. Back-to-back: valid held high, one accept every four cycles.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = OP_ADD;
    instr_rs1   = 5'd2;
    instr_rs2   = 5'd3;
    instr_rd    = 5'd20;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check("b2b_ready", instr_ready, (k % 4) == 0);
      check("b2b_done", done, (k % 4) == 3);
      if ((k % 4) == 3) begin
        check("b2b_data", rf_write_data, ref_rf[2] + ref_rf[3]);
        check("b2b_count", retired_count, ref_count);
        ref_rf[20] = ref_rf[2] + ref_rf[3];
        ref_count  = ref_count + 1;
        $display("b2b retire k=%0d count=%0d", k, ref_count);
      end
      if (k == 15) instr_valid = 1'b0;
    end

    // 7. Randomized program against the reference.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        preload(5'($urandom_range(1, 31)),
                ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 63))
                                            : {32'($urandom), 32'($urandom)});
      sel = $urandom_range(0, 4);
      case (sel)
        0:       rop = OP_NOP;
        1:       rop = OP_STORE;
        2:       rop = OP_ADD;
        3:       rop = OP_SUB;
        default: rop = 7'($urandom_range(4, 127));
      endcase
      r1  = 5'($urandom_range(0, 31));
      r2  = 5'($urandom_range(0, 31));
      rdd = 5'($urandom_range(0, 31));
      run_instr(rop, r1, r2, rdd);
    end

    // 8. Final architectural state.
    @(negedge clk);
    @(negedge clk);
    for (int i = 1; i < 32; i++) check($sformatf("final_r%0d", i), rf_arr[i], ref_rf[i]);
    for (int i = 0; i < 32; i++) check($sformatf("final_m%0d", i), mem_arr[i], ref_mem[i]);
    check("final_count", retired_count, ref_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
